// File: rtl/cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfg_pkg
// Description : Shared config-register index codes, UART frame-state encoding
//               and the report byte builder.
// Revision    : 1.0
// ============================================================================
package cfg_pkg;

    // Index nibbles shared with the host command decoder
    localparam logic [3:0] CFG_IDX_MODE   = 4'h0;
    localparam logic [3:0] CFG_IDX_BRIGHT = 4'hA;
    localparam logic [3:0] CFG_IDX_ANIM   = 4'h2;

    localparam int unsigned CFG_REPORT_BYTES = 3;

    typedef logic [1:0] byte_idx_t;

    localparam byte_idx_t CFG_LAST_IDX = 2'(CFG_REPORT_BYTES - 1);

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_START = 3'd1,
        FS_DATA  = 3'd2,
        FS_STOP  = 3'd3,
        FS_GAP   = 3'd4
    } frame_state_e;

    function automatic logic [7:0] cfg_report_byte(
        input byte_idx_t  idx,
        input logic [3:0] mode_val,
        input logic [3:0] bright_val,
        input logic [3:0] anim_val
    );
        logic [7:0] b;
        case (idx)
            2'd0:    b = {CFG_IDX_MODE,   mode_val};
            2'd1:    b = {CFG_IDX_BRIGHT, bright_val};
            default: b = {CFG_IDX_ANIM,   anim_val};
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 UART byte transmitter with optional idle gap per frame.
// Revision    : 1.0
// ============================================================================
module uart_tx_byte
    import cfg_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FRAME_GAP    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam logic [15:0] c_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] c_BIT_SHORT = 16'(CLKS_PER_BIT - 2);
    localparam logic [15:0] c_GAP_LAST  = (FRAME_GAP == 0) ? 16'd0 : 16'(FRAME_GAP - 1);

    frame_state_e state_q, state_d;
    logic [15:0]  baud_q, baud_d;
    logic [15:0]  gap_q, gap_d;
    logic [2:0]   bit_q, bit_d;
    logic [7:0]   shift_q, shift_d;
    logic         tx_q, tx_d;

    logic w_bit_end;
    logic w_last_cycle;

    assign w_bit_end    = (baud_q == c_BIT_LAST);
    assign w_last_cycle = (baud_q == c_BIT_SHORT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FS_IDLE;
            baud_q  <= 16'd0;
            gap_q   <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // The final cycle of the last stop/gap period is spent in IDLE (tx high),
    // so a byte accepted there starts with no dead cycle between frames.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            FS_IDLE: begin
                tx_d = 1'b1;
                if (valid_i) begin
                    state_d = FS_START;
                    shift_d = data_i;
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    gap_d   = 16'd0;
                    tx_d    = 1'b0;
                end
            end
            FS_START: begin
                if (w_bit_end) begin
                    state_d = FS_DATA;
                    baud_d  = 16'd0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            FS_DATA: begin
                if (w_bit_end) begin
                    baud_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        state_d = FS_STOP;
                        bit_d   = 3'd0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            FS_STOP: begin
                tx_d = 1'b1;
                if ((FRAME_GAP == 0) && w_last_cycle) begin
                    state_d = FS_IDLE;
                    baud_d  = 16'd0;
                end else if ((FRAME_GAP != 0) && w_bit_end) begin
                    state_d = FS_GAP;
                    baud_d  = 16'd0;
                    gap_d   = 16'd0;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            FS_GAP: begin
                tx_d = 1'b1;
                if ((gap_q == c_GAP_LAST) && w_last_cycle) begin
                    state_d = FS_IDLE;
                    baud_d  = 16'd0;
                end else if (w_bit_end) begin
                    baud_d = 16'd0;
                    gap_d  = gap_q + 16'd1;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = FS_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign ready_o = (state_q == FS_IDLE);
    assign tx_o    = tx_q;

endmodule
`default_nettype wire

// File: rtl/config_report_tx.sv
`default_nettype none
// ============================================================================
// Module      : config_report_tx
// Description : On query, snapshots mode/brightness/animation and sends them
//               as a three-byte UART report.
// Revision    : 1.0
// ============================================================================
module config_report_tx
    import cfg_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FRAME_GAP    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       query,
    input  logic [3:0] brightness,
    input  logic [3:0] mode,
    input  logic [3:0] animation_sel,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    logic       busy_q, busy_d;
    logic       done_q, done_d;
    byte_idx_t  idx_q, idx_d;
    logic [3:0] mode_q, mode_d;
    logic [3:0] bright_q, bright_d;
    logic [3:0] anim_q, anim_d;

    logic       w_accept;
    logic       w_ready;
    logic       w_valid;
    logic [7:0] w_byte;

    assign w_accept = query && !busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            idx_q    <= 2'd0;
            mode_q   <= 4'd0;
            bright_q <= 4'd0;
            anim_q   <= 4'd0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            bright_q <= bright_d;
            anim_q   <= anim_d;
        end
    end

    // First byte is built from the live inputs so its start bit coincides
    // with busy rising; later bytes come from the snapshot.
    always_comb begin
        busy_d   = busy_q;
        done_d   = 1'b0;
        idx_d    = idx_q;
        mode_d   = mode_q;
        bright_d = bright_q;
        anim_d   = anim_q;
        w_valid  = 1'b0;
        w_byte   = 8'h00;
        if (w_accept) begin
            mode_d   = mode;
            bright_d = brightness;
            anim_d   = animation_sel;
            busy_d   = 1'b1;
            idx_d    = 2'd0;
            w_valid  = 1'b1;
            w_byte   = cfg_report_byte(2'd0, mode, brightness, animation_sel);
        end else if (busy_q && w_ready) begin
            if (idx_q == CFG_LAST_IDX) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                idx_d  = 2'd0;
            end else begin
                idx_d   = idx_q + 2'd1;
                w_valid = 1'b1;
                w_byte  = cfg_report_byte(idx_q + 2'd1, mode_q, bright_q, anim_q);
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FRAME_GAP    (FRAME_GAP)
    ) u_uart_tx_byte (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (w_valid),
        .data_i  (w_byte),
        .ready_o (w_ready),
        .tx_o    (tx)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: doc/config_report_tx.md
CONFIG_REPORT_TX -- requirements
Module: config_report_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter FRAME_GAP, default 0, meaning extra idle-high bit periods inserted after each stop bit.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 query  input  1  single-cycle request to transmit a config report.
REQ-006 brightness  input  4  current brightness register value.
REQ-007 mode  input  4  current mode register value.
REQ-008 animation_sel  input  4  current animation select value.
REQ-009 tx  output  1  UART serial line: 8N1, LSB first, idle high.
REQ-010 busy  output  1  high from query acceptance until the last stop/gap period ends.
REQ-011 done  output  1  single-cycle pulse on the cycle busy falls.

Function
REQ-012 Report SHALL be 3 bytes in order: {4'h0, mode}, {4'hA, brightness}, {4'h2, animation_sel} (index nibble high, data nibble low, matching the host command encoding).
REQ-013 On query=1 with busy=0, all three values SHALL be snapshotted that cycle; later input changes SHALL NOT affect the report in flight.
REQ-014 busy SHALL rise the cycle after accepted query; start bit SHALL begin the same cycle busy rises.
REQ-015 query while busy=1 SHALL be ignored (no queuing, no restart).
REQ-016 Frame FSM states: IDLE, START, DATA, STOP, GAP; IDLE->START on accept or next byte pending; START->DATA after CLKS_PER_BIT; DATA->STOP after 8 bit periods; STOP->GAP if FRAME_GAP>0 else ->START (bytes remaining) or IDLE; GAP->START/IDLE after FRAME_GAP bit periods.
REQ-017 Each bit SHALL be held on tx for exactly CLKS_PER_BIT cycles; bit counter 0..7 with wrap resetting on START.
REQ-018 Byte index counter 0..2 SHALL advance at end of each STOP/GAP; after byte 2 FSM SHALL return to IDLE.
REQ-019 Total busy duration SHALL be exactly 3*(10+FRAME_GAP)*CLKS_PER_BIT cycles.
REQ-020 tx SHALL be driven from a register (glitch-free); tx=1 in IDLE, STOP, GAP.
REQ-021 Query arriving the same cycle done pulses SHALL be accepted (busy already low that cycle).

Reset
REQ-022 On rst_n=0: tx=1, busy=0, done=0, FSM=IDLE, all counters and snapshot registers 0.
REQ-023 Reset asserted mid-frame SHALL abort immediately; tx returns high next cycle; no partial byte resumes after reset.

Structure
REQ-024 Shared package cfg_pkg SHALL hold CFG_IDX_MODE=4'h0, CFG_IDX_BRIGHT=4'hA, CFG_IDX_ANIM=4'h2 and the frame-state enum; the config receive path SHALL use the same index constants.
REQ-025 One sub-module uart_tx_byte (baud counter, shift register, START/DATA/STOP/GAP sequencing, byte valid/ready handshake) SHALL be instantiated; config_report_tx holds snapshot, byte sequencer, busy/done.
REQ-026 uart_tx_byte handshake: byte accepted when valid&&ready; ready=1 only in IDLE.

Verification (CLKS_PER_BIT=4, FRAME_GAP=0 unless stated)
REQ-027 Reset, mode=3, brightness=7, anim=5, query pulse -> bytes 0x03, 0xA7, 0x25 decoded from tx; busy high exactly 120 cycles; done one pulse.
REQ-028 Change mode to 9 one cycle after query -> first byte still 0x03.
REQ-029 Second query at cycle 40 of a report -> ignored; exactly 3 bytes observed, busy 120 cycles.
REQ-030 Query on the done cycle -> second report starts immediately, tx never idles for a bit period between reports.
REQ-031 rst_n low at cycle 17 of byte 1 -> tx=1 next cycle, busy=0, no further edges until new query.
REQ-032 FRAME_GAP=2, values 0xF/0x0/0x1 -> bytes 0x0F, 0xA0, 0x21, each followed by 8 idle-high cycles; busy 144 cycles.
